// File: rtl/pmem_arbiter_pkg.sv
// rtl/pmem_arbiter_pkg.sv - shared types and constants for the physical-memory arbiter
package pmem_arb_pkg;

  // Arbiter ownership of the pmem port
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEMAND   = 2'd1,
    PREFETCH = 2'd2
  } arb_state_t;

  // Lines are 32 bytes, so the low five address bits never reach pmem
  localparam int LINE_OFFSET_BITS     = 5;
  localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/pmem_arbiter_if.sv
// rtl/pmem_arbiter_if.sv - requester and pmem signals seen by the arbiter
interface pmem_arbiter_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
);

  // Demand miss path
  logic                  dem_read;
  logic                  dem_write;
  logic [ADDR_WIDTH-1:0] dem_addr;
  logic [DATA_WIDTH-1:0] dem_wdata;
  logic                  dem_resp;
  logic [DATA_WIDTH-1:0] dem_rdata;

  // Stream-buffer prefetcher
  logic                  pf_read;
  logic [ADDR_WIDTH-1:0] pf_addr;
  logic                  pf_resp;
  logic [DATA_WIDTH-1:0] pf_rdata;

  // Physical memory port
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_resp;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  dem_read, dem_write, dem_addr, dem_wdata,
    output dem_resp, dem_rdata,
    input  pf_read, pf_addr,
    output pf_resp, pf_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_resp, mem_rdata
  );

  // Requester / memory-model side
  modport master (
    output dem_read, dem_write, dem_addr, dem_wdata,
    input  dem_resp, dem_rdata,
    output pf_read, pf_addr,
    input  pf_resp, pf_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_resp, mem_rdata
  );

endinterface

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - demand-priority pmem arbiter with prefetch starvation guard
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            rst,
  pmem_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t            state_q, state_d;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;

  logic                  busy;
  logic                  dem_req;

  assign dem_req = bus.dem_read | bus.dem_write;

  // Arbitration in IDLE, latch of the winning request, release on mem_resp
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    case (state_q)
      IDLE: begin
        if (bus.pf_read && (starve_cnt_q == LIMIT || !dem_req)) begin
          state_d      = PREFETCH;
          starve_cnt_d = '0;
          addr_d       = {bus.pf_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
          wdata_d      = '0;
          write_d      = 1'b0;
        end else if (dem_req) begin
          state_d = DEMAND;
          addr_d  = {bus.dem_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
          // A simultaneous read+write is treated as a write-back
          write_d = bus.dem_write;
          wdata_d = bus.dem_write ? bus.dem_wdata : '0;
          if (!bus.pf_read) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else begin
          starve_cnt_d = '0;
        end
      end
      DEMAND, PREFETCH: begin
        if (bus.mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, starvation counter and latched request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
    end
  end

  // pmem strobes come only from latched state, so they are glitch-free and held until resp
  assign busy          = (state_q != IDLE);
  assign bus.mem_read  = busy & ~write_q;
  assign bus.mem_write = busy & write_q;
  assign bus.mem_addr  = busy ? addr_q : '0;
  assign bus.mem_wdata = (busy & write_q) ? wdata_q : '0;

  // Completion and read data routed to whichever requester owns the port
  assign bus.dem_resp  = bus.mem_resp & (state_q == DEMAND);
  assign bus.pf_resp   = bus.mem_resp & (state_q == PREFETCH);
  assign bus.dem_rdata = (state_q == DEMAND)   ? bus.mem_rdata : '0;
  assign bus.pf_rdata  = (state_q == PREFETCH) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - self-checking bench for pmem_arbiter
module tb_pmem_arbiter;
  import pmem_arb_pkg::*;

  localparam int DW = 256;
  localparam int AW = 32;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return a & ~AW'(32'h1f);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In an IDLE cycle nothing reaches pmem and no resp pulses, even with a stray mem_resp
  task automatic check_idle(input string tag);
    bus.mem_resp  = 1'($urandom_range(0, 1));
    bus.mem_rdata = rnd_line();
    #1;
    chk1({tag, ".idle_rd"}, bus.mem_read, 1'b0);
    chk1({tag, ".idle_wr"}, bus.mem_write, 1'b0);
    chka({tag, ".idle_addr"}, bus.mem_addr, '0);
    chk1({tag, ".idle_dresp"}, bus.dem_resp, 1'b0);
    chk1({tag, ".idle_presp"}, bus.pf_resp, 1'b0);
    chkd({tag, ".idle_drdata"}, bus.dem_rdata, '0);
  endtask

  // who: 1 = demand, 2 = prefetch. Starts in an IDLE cycle with requests driven, ends in the following IDLE cycle.
  task automatic run_txn(input int who, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int lat, input string tag);
    logic [DW-1:0] rd;
    tick();
    bus.mem_resp = 1'b0;
    if (who == 1) begin
      bus.dem_addr  = $urandom;
      bus.dem_wdata = rnd_line();
    end else begin
      bus.pf_addr = $urandom;
    end
    for (int c = 0; c <= lat; c++) begin
      rd = rnd_line();
      bus.mem_rdata = rd;
      bus.mem_resp  = (c == lat);
      #1;
      chk1({tag, ".mem_read"}, bus.mem_read, !wr);
      chk1({tag, ".mem_write"}, bus.mem_write, wr);
      chka({tag, ".mem_addr"}, bus.mem_addr, line_of(addr));
      chkd({tag, ".mem_wdata"}, bus.mem_wdata, wr ? wdata : '0);
      chk1({tag, ".dem_resp"}, bus.dem_resp, (who == 1) && (c == lat));
      chk1({tag, ".pf_resp"}, bus.pf_resp, (who == 2) && (c == lat));
      if (c == lat) begin
        chkd({tag, ".dem_rdata"}, bus.dem_rdata, (who == 1) ? rd : '0);
        chkd({tag, ".pf_rdata"}, bus.pf_rdata, (who == 2) ? rd : '0);
      end
      tick();
    end
    bus.mem_resp = 1'b0;
  endtask

  logic [DW-1:0]  w;
  logic           dem_pend, dem_wr, pf_pend;
  logic [AW-1:0]  dem_a, pf_a;
  logic [DW-1:0]  dem_wd;
  int             bypass;
  int             winner;

  initial begin
    rst = 1'b1;
    bus.dem_read = 1'b1; bus.dem_write = 1'b0; bus.dem_addr = 32'h40; bus.dem_wdata = '0;
    bus.pf_read = 1'b1;  bus.pf_addr = 32'h80;
    bus.mem_resp = 1'b1; bus.mem_rdata = rnd_line();
    #12;
    chk1("rst.mem_read", bus.mem_read, 1'b0);
    chk1("rst.mem_write", bus.mem_write, 1'b0);
    chka("rst.mem_addr", bus.mem_addr, '0);
    chk1("rst.dem_resp", bus.dem_resp, 1'b0);
    chk1("rst.pf_resp", bus.pf_resp, 1'b0);
    chka("rst.starve", AW'(dut.starve_cnt_q), '0);
    tick();
    bus.dem_read = 1'b0; bus.pf_read = 1'b0; bus.mem_resp = 1'b0;
    rst = 1'b0;
    tick();

    // Lone demand read
    bus.dem_read = 1'b1; bus.dem_addr = 32'h0000_1234;
    check_idle("t1");
    run_txn(1, 1'b0, 32'h0000_1234, '0, 3, "t1");
    bus.dem_read = 1'b0;
    check_idle("t1.after");

    // Simultaneous demand and prefetch
    bus.dem_read = 1'b1; bus.dem_addr = 32'h100;
    bus.pf_read = 1'b1;  bus.pf_addr = 32'h200;
    check_idle("t2");
    run_txn(1, 1'b0, 32'h100, '0, 1, "t2.dem");
    bus.dem_read = 1'b0;
    bus.pf_addr = 32'h200;
    check_idle("t2.bubble");
    run_txn(2, 1'b0, 32'h200, '0, 2, "t2.pf");
    bus.pf_read = 1'b0;
    chka("t2.starve", AW'(dut.starve_cnt_q), '0);

    // Starvation: continuous demand while a prefetch waits
    bus.pf_read = 1'b1; bus.pf_addr = 32'h4000;
    for (int i = 0; i <= SL; i++) begin
      dem_a = $urandom;
      bus.dem_read = 1'b1; bus.dem_addr = dem_a;
      check_idle("t3");
      if (i < SL) begin
        run_txn(1, 1'b0, dem_a, '0, 1, "t3.dem");
        chka("t3.starve_inc", AW'(dut.starve_cnt_q), AW'(i + 1));
      end else begin
        run_txn(2, 1'b0, 32'h4000, '0, 1, "t3.pf");
        chka("t3.starve_clr", AW'(dut.starve_cnt_q), '0);
      end
      bus.pf_addr = 32'h4000;
    end
    bus.pf_read = 1'b0; bus.dem_read = 1'b0;
    tick();

    // Demand write, then read+write together
    w = {8{32'hDEAD_BEEF}};
    bus.dem_write = 1'b1; bus.dem_addr = 32'h8008; bus.dem_wdata = w;
    check_idle("t4");
    run_txn(1, 1'b1, 32'h8008, w, 2, "t4.wr");
    w = rnd_line();
    bus.dem_read = 1'b1; bus.dem_write = 1'b1; bus.dem_addr = 32'h9000; bus.dem_wdata = w;
    check_idle("t4.rw");
    run_txn(1, 1'b1, 32'h9000, w, 0, "t4.rw");
    bus.dem_read = 1'b0; bus.dem_write = 1'b0;

    // Asynchronous reset in the middle of a prefetch
    bus.pf_read = 1'b1; bus.pf_addr = 32'h300;
    check_idle("t5");
    tick();
    bus.mem_resp = 1'b0;
    chk1("t5.granted", bus.mem_read, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("t5.rst_mem_read", bus.mem_read, 1'b0);
    chk1("t5.rst_state_idle", dut.state_q == IDLE, 1'b1);
    bus.pf_read = 1'b0;
    tick();
    rst = 1'b0;
    bus.mem_resp = 1'b1;
    #1;
    chk1("t5.stray_pf_resp", bus.pf_resp, 1'b0);
    chk1("t5.stray_dem_resp", bus.dem_resp, 1'b0);
    tick();
    bus.mem_resp = 1'b0;
    tick();

    // Randomized traffic against a transaction-level model
    dem_pend = 1'b0; pf_pend = 1'b0; bypass = 0;
    dem_wr = 1'b0; dem_a = '0; dem_wd = '0; pf_a = '0;
    for (int n = 0; n < 80; n++) begin
      if (!dem_pend && $urandom_range(0, 2) != 0) begin
        dem_pend = 1'b1;
        dem_a    = $urandom;
        dem_wd   = rnd_line();
        case ($urandom_range(0, 2))
          0: begin bus.dem_read = 1'b1; bus.dem_write = 1'b0; dem_wr = 1'b0; end
          1: begin bus.dem_read = 1'b0; bus.dem_write = 1'b1; dem_wr = 1'b1; end
          default: begin bus.dem_read = 1'b1; bus.dem_write = 1'b1; dem_wr = 1'b1; end
        endcase
      end else if (dem_pend && $urandom_range(0, 9) == 0) begin
        dem_pend = 1'b0;
        bus.dem_read = 1'b0; bus.dem_write = 1'b0;
      end
      if (!pf_pend && $urandom_range(0, 1) != 0) begin
        pf_pend = 1'b1;
        pf_a    = $urandom;
      end else if (pf_pend && $urandom_range(0, 11) == 0) begin
        pf_pend = 1'b0;
      end
      bus.pf_read   = pf_pend;
      bus.pf_addr   = pf_a;
      bus.dem_addr  = dem_a;
      bus.dem_wdata = dem_wd;

      // Prefetch wins when alone or after SL demand grants have passed it by
      if (pf_pend && (bypass == SL || !dem_pend)) winner = 2;
      else if (dem_pend) winner = 1;
      else winner = 0;

      check_idle("rnd");
      if (winner == 0) begin
        bypass = 0;
        tick();
        bus.mem_resp = 1'b0;
        chka("rnd.starve_none", AW'(dut.starve_cnt_q), '0);
      end else if (winner == 1) begin
        bypass = pf_pend ? ((bypass < SL) ? bypass + 1 : SL) : 0;
        run_txn(1, dem_wr, dem_a, dem_wd, $urandom_range(0, 3), "rnd.dem");
        chka("rnd.starve_dem", AW'(dut.starve_cnt_q), AW'(bypass));
        dem_pend = 1'b0;
        bus.dem_read = 1'b0; bus.dem_write = 1'b0;
      end else begin
        bypass = 0;
        run_txn(2, 1'b0, pf_a, '0, $urandom_range(0, 3), "rnd.pf");
        chka("rnd.starve_pf", AW'(dut.starve_cnt_q), '0);
        pf_pend = 1'b0;
        bus.pf_read = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
